// File: rtl/bcd_run_counter.sv
// Two-digit BCD run/stop counter with synchronized, debounced pushbuttons.
// Run button cycles IDLE/RUN/HOLD, clear button returns to IDLE at 00.
//
// state | meaning
// IDLE  | stopped, count forced to 00
// RUN   | prescaler advancing, count steps every TICK_DIV cycles
// HOLD  | stopped, count and prescaler retained
module bcd_run_counter #(
  parameter int TICK_DIV  = 10_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_run,
  input  logic       btn_clr,
  input  logic       up_dn,
  output logic [3:0] dec0,
  output logic [3:0] dec1,
  output logic       running,
  output logic       wrap
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

  // bit 0 = run, bit 1 = clear, bit 2 = direction
  logic [2:0]    s1_q, s2_q;
  logic [1:0]    vld_q;
  logic [DW-1:0] db_cnt_q [2];
  logic [DW-1:0] db_cnt_d [2];
  logic [1:0]    db_q, db_d, db_prev_q, arm_q, arm_d, press;
  logic          press_run, press_clr, step;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    dec0_q, dec0_d, dec1_q, dec1_d;
  logic          running_q, running_d, wrap_q, wrap_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s2_q        <= '0;
      vld_q       <= '0;
      db_q        <= '0;
      db_prev_q   <= '0;
      arm_q       <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      s1_q        <= {up_dn, btn_clr, btn_run};
      s2_q        <= s1_q;
      vld_q       <= {vld_q[0], 1'b1};
      db_q        <= db_d;
      db_prev_q   <= db_q;
      arm_q       <= arm_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
    end
  end

  // A button only arms once its synchronizer has shown it released after
  // reset, so a button held through reset cannot produce a press.
  always_comb begin
    db_d  = db_q;
    arm_d = arm_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) db_d[i] = s2_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
      if (vld_q[1] && !s2_q[i]) arm_d[i] = 1'b1;
    end
  end

  assign press     = db_q & ~db_prev_q & arm_q;
  assign press_run = press[0];
  assign press_clr = press[1];
  assign step      = (state_q == S_RUN) && (pre_q == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pre_q     <= '0;
      dec0_q    <= '0;
      dec1_q    <= '0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      dec0_q    <= dec0_d;
      dec1_q    <= dec1_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    dec0_d  = dec0_q;
    dec1_d  = dec1_q;
    wrap_d  = 1'b0;
    if (press_clr) begin
      state_d = S_IDLE;
      pre_d   = '0;
      dec0_d  = 4'd0;
      dec1_d  = 4'd0;
    end else if (press_run) begin
      // a step landing in the same cycle is dropped
      if (state_q == S_RUN) begin
        state_d = S_HOLD;
      end else begin
        state_d = S_RUN;
        pre_d   = '0;
      end
    end else if (step) begin
      pre_d = '0;
      if (s2_q[2]) begin
        if (dec0_q == 4'd9) begin
          dec0_d = 4'd0;
          if (dec1_q == 4'd9) begin
            dec1_d = 4'd0;
            wrap_d = 1'b1;
          end else begin
            dec1_d = dec1_q + 4'd1;
          end
        end else begin
          dec0_d = dec0_q + 4'd1;
        end
      end else begin
        if (dec0_q == 4'd0) begin
          dec0_d = 4'd9;
          if (dec1_q == 4'd0) begin
            dec1_d = 4'd9;
            wrap_d = 1'b1;
          end else begin
            dec1_d = dec1_q - 4'd1;
          end
        end else begin
          dec0_d = dec0_q - 4'd1;
        end
      end
    end else if (state_q == S_RUN) begin
      pre_d = pre_q + 1'b1;
    end
    running_d = (state_d == S_RUN);
  end

  assign dec0    = dec0_q;
  assign dec1    = dec1_q;
  assign running = running_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_run_counter.sv
// Directed bench for bcd_run_counter with TICK_DIV=4, DB_CYCLES=3.
// A clean press changes outputs on the 6th rising edge after the button rises.
module tb_bcd_run_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_run = 1'b0;
  logic       btn_clr = 1'b0;
  logic       up_dn = 1'b1;
  logic [3:0] dec0, dec1;
  logic       running, wrap;
  int         errors = 0;
  int         checks = 0;

  bcd_run_counter #(.TICK_DIV(4), .DB_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .btn_run(btn_run), .btn_clr(btn_clr),
    .up_dn(up_dn), .dec0(dec0), .dec1(dec1), .running(running), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; btn_run = 1'b0; btn_clr = 1'b0; up_dn = 1'b1;
    tick(3);
    checks++;
    if ({dec1, dec0, running, wrap} !== 10'h0) begin
      errors++; $display("FAIL reset_state: got %h%h run=%b wrap=%b expected 00 0 0", dec1, dec0, running, wrap);
    end
    rst_n = 1'b1;
    tick(3);
    checks++;
    if ({dec1, dec0, running, wrap} !== 10'h0) begin
      errors++; $display("FAIL reset_release: got %h%h run=%b wrap=%b expected 00 0 0", dec1, dec0, running, wrap);
    end
  endtask

  task automatic test_run_start;
    btn_run = 1'b1;
    tick(5);
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL start_early: running=%b expected 0", running); end
    tick(1);
    checks++;
    if ({running, dec1, dec0} !== 9'h100) begin
      errors++; $display("FAIL start_entry: run=%b count=%h%h expected 1 00", running, dec1, dec0);
    end
    tick(3);
    checks++;
    if ({dec1, dec0} !== 8'h00) begin errors++; $display("FAIL first_step_early: count=%h%h expected 00", dec1, dec0); end
    tick(1);
    checks++;
    if ({dec1, dec0} !== 8'h01) begin errors++; $display("FAIL first_step: count=%h%h expected 01", dec1, dec0); end
    tick(4);
    checks++;
    if ({dec1, dec0} !== 8'h02) begin errors++; $display("FAIL second_step: count=%h%h expected 02", dec1, dec0); end
    tick(4);
    checks++;
    if ({dec1, dec0} !== 8'h03) begin errors++; $display("FAIL third_step: count=%h%h expected 03", dec1, dec0); end
    btn_run = 1'b0;
    tick(6);
  endtask

  task automatic test_wrap;
    btn_clr = 1'b1;
    tick(6);
    checks++;
    if ({running, dec1, dec0} !== 9'h000) begin
      errors++; $display("FAIL clear_from_run: run=%b count=%h%h expected 0 00", running, dec1, dec0);
    end
    btn_clr = 1'b0;
    tick(6);
    btn_run = 1'b1;
    tick(6);
    btn_run = 1'b0;
    tick(392);
    checks++;
    if ({dec1, dec0} !== 8'h98) begin errors++; $display("FAIL reach_98: count=%h%h expected 98", dec1, dec0); end
    tick(4);
    checks++;
    if ({dec1, dec0, wrap} !== 9'h132) begin
      errors++; $display("FAIL up_99: count=%h%h wrap=%b expected 99 0", dec1, dec0, wrap);
    end
    tick(4);
    checks++;
    if ({dec1, dec0, wrap} !== 9'h001) begin
      errors++; $display("FAIL up_wrap: count=%h%h wrap=%b expected 00 1", dec1, dec0, wrap);
    end
    tick(1);
    checks++;
    if ({dec1, dec0, wrap} !== 9'h000) begin
      errors++; $display("FAIL up_wrap_pulse: count=%h%h wrap=%b expected 00 0", dec1, dec0, wrap);
    end
    up_dn = 1'b0;
    tick(3);
    checks++;
    if ({dec1, dec0, wrap} !== 9'h133) begin
      errors++; $display("FAIL down_wrap: count=%h%h wrap=%b expected 99 1", dec1, dec0, wrap);
    end
    tick(1);
    checks++;
    if (wrap !== 1'b0) begin errors++; $display("FAIL down_wrap_pulse: wrap=%b expected 0", wrap); end
    tick(4);
    checks++;
    if ({dec1, dec0} !== 8'h98) begin errors++; $display("FAIL down_step: count=%h%h expected 98", dec1, dec0); end
  endtask

  task automatic test_glitch;
    up_dn = 1'b1;
    btn_clr = 1'b1;
    tick(6);
    btn_clr = 1'b0;
    tick(6);
    for (int i = 0; i < 10; i++) begin
      btn_run = (i % 2 == 0);
      tick(1);
      checks++;
      if (running !== 1'b0) begin errors++; $display("FAIL bounce_%0d: running=%b expected 0", i, running); end
    end
    btn_run = 1'b1;
    tick(5);
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL bounce_settle_early: running=%b expected 0", running); end
    tick(1);
    checks++;
    if ({running, dec1, dec0} !== 9'h100) begin
      errors++; $display("FAIL bounce_press: run=%b count=%h%h expected 1 00", running, dec1, dec0);
    end
    tick(20);
    checks++;
    if ({running, dec1, dec0} !== 9'h105) begin
      errors++; $display("FAIL single_event: run=%b count=%h%h expected 1 05", running, dec1, dec0);
    end
    btn_run = 1'b0;
  endtask

  task automatic test_clear_priority;
    tick(124);
    btn_run = 1'b1;
    btn_clr = 1'b1;
    tick(5);
    checks++;
    if ({running, dec1, dec0} !== 9'h137) begin
      errors++; $display("FAIL prio_before: run=%b count=%h%h expected 1 37", running, dec1, dec0);
    end
    tick(1);
    checks++;
    if ({running, wrap, dec1, dec0} !== 10'h000) begin
      errors++; $display("FAIL prio_clear: run=%b wrap=%b count=%h%h expected 0 0 00", running, wrap, dec1, dec0);
    end
    btn_run = 1'b0;
    btn_clr = 1'b0;
    tick(6);
  endtask

  task automatic test_hold;
    btn_run = 1'b1;
    tick(6);
    btn_run = 1'b0;
    tick(176);
    btn_run = 1'b1;
    tick(6);
    checks++;
    if ({running, dec1, dec0} !== 9'h045) begin
      errors++; $display("FAIL hold_enter: run=%b count=%h%h expected 0 45", running, dec1, dec0);
    end
    btn_run = 1'b0;
    tick(20);
    checks++;
    if ({running, dec1, dec0} !== 9'h045) begin
      errors++; $display("FAIL hold_keep: run=%b count=%h%h expected 0 45", running, dec1, dec0);
    end
    btn_run = 1'b1;
    tick(6);
    btn_run = 1'b0;
    checks++;
    if ({running, dec1, dec0} !== 9'h145) begin
      errors++; $display("FAIL hold_resume: run=%b count=%h%h expected 1 45", running, dec1, dec0);
    end
    tick(3);
    checks++;
    if ({dec1, dec0} !== 8'h45) begin errors++; $display("FAIL resume_step_early: count=%h%h expected 45", dec1, dec0); end
    tick(1);
    checks++;
    if ({dec1, dec0} !== 8'h46) begin errors++; $display("FAIL resume_step: count=%h%h expected 46", dec1, dec0); end
  endtask

  task automatic test_back_to_back;
    tick(2);
    btn_run = 1'b1;
    tick(5);
    checks++;
    if ({running, dec1, dec0} !== 9'h147) begin
      errors++; $display("FAIL run_step_before: run=%b count=%h%h expected 1 47", running, dec1, dec0);
    end
    tick(1);
    checks++;
    if ({running, dec1, dec0} !== 9'h047) begin
      errors++; $display("FAIL run_step_coincide: run=%b count=%h%h expected 0 47", running, dec1, dec0);
    end
    btn_run = 1'b0;
    tick(6);
    checks++;
    if ({running, dec1, dec0} !== 9'h047) begin
      errors++; $display("FAIL run_step_after: run=%b count=%h%h expected 0 47", running, dec1, dec0);
    end
  endtask

  task automatic test_async_reset;
    btn_run = 1'b1;
    tick(66);
    checks++;
    if ({running, dec1, dec0} !== 9'h162) begin
      errors++; $display("FAIL reach_62: run=%b count=%h%h expected 1 62", running, dec1, dec0);
    end
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({running, wrap, dec1, dec0} !== 10'h000) begin
      errors++; $display("FAIL async_reset: run=%b wrap=%b count=%h%h expected 0 0 00", running, wrap, dec1, dec0);
    end
    tick(2);
    rst_n = 1'b1;
    tick(15);
    checks++;
    if ({running, dec1, dec0} !== 9'h000) begin
      errors++; $display("FAIL held_through_reset: run=%b count=%h%h expected 0 00", running, dec1, dec0);
    end
    btn_run = 1'b0;
    tick(6);
    btn_run = 1'b1;
    tick(6);
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL rearm_press: running=%b expected 1", running); end
    btn_run = 1'b0;
    tick(6);
  endtask

  initial begin
    test_reset();
    test_run_start();
    test_wrap();
    test_glitch();
    test_clear_priority();
    test_hold();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
